// File: rtl/tile_stream_loader.sv
// Byte-stream front end for the ping-pong input buffer. Packs bytes into
// masked words, fills one bank, and hands it over once the reader is free.
module tile_stream_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int SRAM_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  input  logic                    s_last,
  output logic                    input_wr_en,
  output logic [ADDR_WIDTH-1:0]   input_wr_addr,
  output logic [SRAM_WIDTH-1:0]   input_wr_data,
  output logic [SRAM_WIDTH/8-1:0] input_wr_mask,
  output logic                    bank_sel,
  input  logic                    rd_done,
  output logic                    tile_valid,
  output logic [ADDR_WIDTH:0]     tile_words,
  output logic                    tile_overflow
);

  localparam int BYTES = SRAM_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_FILL, S_DRAIN, S_SWAP_WAIT} state_e;

  state_e                  state_q;
  logic                    drain_cnt_q;
  logic [BW-1:0]           byte_cnt_q;
  logic [SRAM_WIDTH-1:0]   pack_data_q;
  logic [CW-1:0]           word_cnt_q;
  logic                    overflow_q;
  logic                    rd_busy_q;

  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   stage_addr_q;
  logic [SRAM_WIDTH-1:0]   stage_data_q;
  logic [BYTES-1:0]        stage_mask_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [SRAM_WIDTH-1:0]   wr_data_q;
  logic [BYTES-1:0]        wr_mask_q;

  logic                    bank_sel_q;
  logic                    tile_valid_q;
  logic [CW-1:0]           tile_words_q;
  logic                    tile_overflow_q;

  logic                    accept;
  logic                    word_done;
  logic                    room;
  logic                    swap;
  logic [SRAM_WIDTH-1:0]   pack_data_d;
  logic [BYTES-1:0]        pack_mask_d;
  logic                    rd_busy_d;

  assign s_ready   = (state_q == S_FILL) && !rst;
  assign accept    = s_valid && s_ready;
  assign word_done = accept && (s_last || byte_cnt_q == BW'(BYTES - 1));
  assign room      = word_cnt_q < CW'(DEPTH);
  assign swap      = (state_q == S_SWAP_WAIT) && (!rd_busy_q || rd_done);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pack_data_d = pack_data_q | (SRAM_WIDTH'(s_data) << {byte_cnt_q, 3'b000});
    pack_mask_d = '0;
    for (int k = 0; k < BYTES; k++) begin
      pack_mask_d[k] = (BW'(k) <= byte_cnt_q);
    end
    rd_busy_d = rd_busy_q;
    if (swap) begin
      rd_busy_d = 1'b1;
    end else if (rd_done) begin
      rd_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples the same pre-edge values.
    if (rst) begin
      state_q         <= S_FILL;
      drain_cnt_q     <= 1'b0;
      byte_cnt_q      <= '0;
      pack_data_q     <= '0;
      word_cnt_q      <= '0;
      overflow_q      <= 1'b0;
      rd_busy_q       <= 1'b0;
      wr_en_q         <= 1'b0;
      stage_addr_q    <= '0;
      stage_data_q    <= '0;
      stage_mask_q    <= '0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      wr_mask_q       <= '0;
      bank_sel_q      <= 1'b0;
      tile_valid_q    <= 1'b0;
      tile_words_q    <= '0;
      tile_overflow_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      tile_valid_q <= 1'b0;
      rd_busy_q    <= rd_busy_d;

      // The word trails its strobe by one cycle, matching the buffer's registered enable.
      if (wr_en_q) begin
        wr_addr_q <= stage_addr_q;
        wr_data_q <= stage_data_q;
        wr_mask_q <= stage_mask_q;
      end

      case (state_q)
        S_FILL: begin
          if (accept) begin
            if (word_done) begin
              byte_cnt_q  <= '0;
              pack_data_q <= '0;
              if (room) begin
                wr_en_q      <= 1'b1;
                stage_addr_q <= word_cnt_q[ADDR_WIDTH-1:0];
                stage_data_q <= pack_data_d;
                stage_mask_q <= pack_mask_d;
                word_cnt_q   <= word_cnt_q + 1'b1;
              end else begin
                overflow_q <= 1'b1;
              end
            end else begin
              byte_cnt_q  <= byte_cnt_q + 1'b1;
              pack_data_q <= pack_data_d;
            end
            if (s_last) begin
              state_q     <= S_DRAIN;
              drain_cnt_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt_q <= 1'b1;
          if (drain_cnt_q) begin
            state_q <= S_SWAP_WAIT;
          end
        end
        S_SWAP_WAIT: begin
          if (swap) begin
            bank_sel_q      <= ~bank_sel_q;
            tile_valid_q    <= 1'b1;
            tile_words_q    <= word_cnt_q;
            tile_overflow_q <= overflow_q;
            word_cnt_q      <= '0;
            overflow_q      <= 1'b0;
            byte_cnt_q      <= '0;
            state_q         <= S_FILL;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign input_wr_en   = wr_en_q;
  assign input_wr_addr = wr_addr_q;
  assign input_wr_data = wr_data_q;
  assign input_wr_mask = wr_mask_q;
  assign bank_sel      = bank_sel_q;
  assign tile_valid    = tile_valid_q;
  assign tile_words    = tile_words_q;
  assign tile_overflow = tile_overflow_q;

endmodule

// File: doc/tile_stream_loader.md
Name: tile_stream_loader

Overview:
- Writer-side front end for the ping-pong input buffer: the data loader that drives the buffer's write port and its bank select.
- Accepts a byte stream (valid/ready) of one image tile at a time and packs bytes little-endian into SRAM_WIDTH-bit words with byte masks.
- Writes the words into the current fill bank starting at address 0.
- On tile end, hands the filled bank to the systolic-array reader by toggling bank_sel. The handover happens only after the reader has released its previous bank.

Parameters:
ADDR_WIDTH, 8, buffer word-address width; tile capacity DEPTH = 2^ADDR_WIDTH words
SRAM_WIDTH, 32, buffer word width; BYTES = SRAM_WIDTH/8 bytes per word

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
s_valid  input  1  byte-stream valid
s_ready  output  1  byte-stream ready
s_data  input  8  stream byte
s_last  input  1  final byte of tile, qualified by s_valid&s_ready
input_wr_en  output  1  write strobe to buffer; leads its addr/data/mask by one cycle
input_wr_addr  output  ADDR_WIDTH  word address
input_wr_data  output  SRAM_WIDTH  packed word
input_wr_mask  output  BYTES  byte-enable mask
bank_sel  output  1  ping-pong select; 0 = bank0 being filled
rd_done  input  1  one-cycle pulse: reader has finished with its bank
tile_valid  output  1  one-cycle pulse: new tile handed to reader
tile_words  output  ADDR_WIDTH+1  words in handed tile, valid with tile_valid
tile_overflow  output  1  tile exceeded DEPTH words, valid with tile_valid

Behaviour:
- Reset values: all outputs 0, FSM in FILL, byte count 0, word address 0, rd_busy 0, partial word discarded. s_ready is 1 in the first cycle after reset deasserts.
- Internal flag rd_busy: 1 while the reader owns the non-fill bank. Next value:
  - 1 on swap (swap wins over rd_done);
  - else 0 on rd_done;
  - else held.
  - rd_done while rd_busy=0 is ignored.
- FSM states FILL, DRAIN, SWAP_WAIT.
- FILL:
  - s_ready=1; one byte accepted per cycle when s_valid.
  - Byte k of the word (k=0..BYTES-1) goes to bits [8k+7:8k].
  - A word is emitted when the BYTES-th byte or s_last is accepted.
- Word emission, word completed at cycle c:
  - input_wr_en=1 for exactly cycle c+1.
  - addr/data/mask registered and presented from cycle c+2, held until the next word.
  - Partial word: unfilled bytes are 0; mask bits set only for filled bytes (e.g. 1 byte gives mask 0x1).
  - Address increments per emitted word.
- Sustained throughput: 1 byte/cycle, with one wr_en per BYTES accepted bytes.
- Overflow:
  - After word DEPTH-1 is emitted without s_last, further bytes are accepted and dropped (no wr_en) until s_last.
  - The tile then closes with tile_words=DEPTH and tile_overflow=1.
  - The address never wraps within a tile.
- Tile close, s_last accepted at cycle c: DRAIN during c+1 and c+2 (s_ready=0), then SWAP_WAIT from c+3 (s_ready=0).
- SWAP_WAIT, in any cycle t where (rd_busy==0 or rd_done==1):
  - bank_sel toggles and tile_valid=1 in cycle t+1;
  - tile_words and tile_overflow are presented in cycle t+1;
  - state returns to FILL at t+1;
  - address and byte count reset to 0.
  - Earliest handover is c+4.
- bank_sel never changes within 2 cycles after a wr_en pulse, so the buffer's registered enable and bank select always pair with the correct addr/data.
- tile_valid is always one cycle wide; tile_words is in the range 1..DEPTH.
- Reset mid-operation: immediate return to the reset state. In-flight wr_en/data are cancelled and the next tile starts at bank 0, address 0.

Test Plan:
- Bytes 0x01..0x08, s_last on 0x08, rd_busy=0 -> writes addr0=0x04030201/mask 0xF and addr1=0x08070605/mask 0xF; each wr_en one cycle before its data; bank_sel 0->1 and tile_valid at c+4 with tile_words=2.
- Bytes 0x01..0x05 with last -> second word addr1=0x00000005, mask 0x1; tile_words=2, tile_overflow=0.
- Second tile while rd_busy=1 -> s_ready held 0 in SWAP_WAIT and no toggle; rd_done pulse at t -> bank_sel 1->0 and tile_valid at t+1; rd_done coinciding with the swap cycle leaves rd_busy=1.
- ADDR_WIDTH=2, 20 bytes with last -> exactly 4 writes at addr 0..3, bytes 17-20 dropped, tile_words=4, tile_overflow=1.
- Assert rst after 6 bytes of a tile -> all outputs 0, bank_sel=0; the following 4-byte tile writes addr0 with mask 0xF and hands over with tile_words=1.
- Continuous s_valid with 16 bytes -> s_ready stays 1 throughout FILL; wr_en pulses every 4th cycle; addresses 0..3.
